peak_meter15: RTL and testbench



---
 rtl/peak_meter15.sv | 166 ++++++++++++++++
 tb/tb_peak_meter15.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/peak_meter15.sv
// peak_meter15: per-channel peak-hold/decay level meter.
// Stage 1 registers the saturated 15-bit magnitude of each signed sample.
// Stage 2 compares it against the held peak and runs the IDLE/HOLD/DECAY
// envelope FSM.
// Optional macro PEAK_OVER_STICKY_EN: when defined, 'over' latches until
// clr/rst. Otherwise it pulses with the peak_vld of the clipped sample.
module peak_meter15 #(
    parameter int HOLD_SMPLS  = 1024,
    parameter int DECAY_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        smpl_vld,
    input  logic [15:0] smpl,
    input  logic        clr,
    output logic [14:0] peak,
    output logic        peak_vld,
    output logic        over,
    output logic        hold_active
);

    localparam int CNT_W = $clog2(HOLD_SMPLS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_SMPLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    // Stage-1 signals
    logic [15:0] abs_d;
    logic [14:0] mag_d;
    logic        clip_d;
    logic [14:0] mag_q;
    logic        clip_q;
    logic        mag_vld_q;

    // Stage-2 signals
    state_t          state_q;
    logic [14:0]     peak_q;
    logic [CNT_W-1:0] cnt_q;
    logic            peak_vld_q;
    logic            over_q;
    logic            hold_q;

    logic            mag_gt;
    logic            mag_eq;
    logic [14:0]     step_d;
    logic [14:0]     decay_d;

    // Absolute value with saturation; -32768 has no 15-bit magnitude.
    always_comb begin
        abs_d  = smpl[15] ? (~smpl + 16'd1) : smpl;
        mag_d  = abs_d[15] ? 15'h7FFF : abs_d[14:0];
        clip_d = (mag_d == 15'h7FFF);
    end

    // Stage 1: capture magnitude and clip flag of each qualified sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q     <= '0;
            clip_q    <= 1'b0;
            mag_vld_q <= 1'b0;
        end else if (clr) begin
            // Drop both the in-flight sample and any coincident new one.
            mag_vld_q <= 1'b0;
        end else begin
            mag_vld_q <= smpl_vld;
            if (smpl_vld) begin
                mag_q  <= mag_d;
                clip_q <= clip_d;
            end
        end
    end

    // Magnitude comparator and decay target; step is at least 1, result
    // is clamped at the incoming magnitude so it never underflows.
    always_comb begin
        mag_gt = (mag_q > peak_q);
        mag_eq = (mag_q == peak_q);
        step_d = peak_q >> DECAY_SHIFT;
        if (step_d == '0) begin
            step_d = 15'd1;
        end
        if (step_d > peak_q) begin
            decay_d = '0;
        end else begin
            decay_d = peak_q - step_d;
        end
        if (decay_d < mag_q) begin
            decay_d = mag_q;
        end
    end

    // Stage 2: envelope FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= IDLE;
            peak_q     <= '0;
            cnt_q      <= '0;
            peak_vld_q <= 1'b0;
            over_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            peak_vld_q <= mag_vld_q;
`ifdef PEAK_OVER_STICKY_EN
            over_q     <= over_q | (mag_vld_q & clip_q);
`else
            over_q     <= mag_vld_q & clip_q;
`endif
            if (mag_vld_q) begin
                case (state_q)
                    IDLE: begin
                        if (mag_gt) begin
                            peak_q  <= mag_q;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                            hold_q  <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (mag_gt) begin
                            peak_q <= mag_q;
                            cnt_q  <= '0;
                        end else if (mag_eq) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            // Peak is kept for this sample; decay starts next.
                            cnt_q   <= '0;
                            state_q <= DECAY;
                            hold_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DECAY: begin
                        if (mag_gt || mag_eq) begin
                            peak_q  <= mag_q;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                            hold_q  <= 1'b1;
                        end else begin
                            peak_q <= decay_d;
                            if (decay_d == '0) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        peak_q  <= '0;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign peak        = peak_q;
    assign peak_vld    = peak_vld_q;
    assign over        = over_q;
    assign hold_active = hold_q;

endmodule

// File: tb/tb_peak_meter15.sv
// tb_peak_meter15: directed scoreboard bench for peak_meter15
// (HOLD_SMPLS=4, DECAY_SHIFT=2).
module tb_peak_meter15;

`ifdef PEAK_OVER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        smpl_vld;
    logic [15:0] smpl;
    logic        clr;
    logic [14:0] peak;
    logic        peak_vld;
    logic        over;
    logic        hold_active;

    typedef struct packed {
        logic [14:0] pk;
        logic        ov;
        logic        hd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   fail_cnt = 0;
    logic idle_over_exp = 1'b0;

    peak_meter15 #(
        .HOLD_SMPLS (4),
        .DECAY_SHIFT(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .smpl_vld   (smpl_vld),
        .smpl       (smpl),
        .clr        (clr),
        .peak       (peak),
        .peak_vld   (peak_vld),
        .over       (over),
        .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s, input logic [14:0] p, input logic o, input logic h);
        exp_t e;
        e.pk = p;
        e.ov = o;
        e.hd = h;
        smpl_vld = 1'b1;
        smpl     = s;
        exp_q.push_back(e);
        tick();
        smpl_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_peak"}, 32'(peak), 32'd0);
        check({tag, "_over"}, 32'(over), 32'd0);
        check({tag, "_hold"}, 32'(hold_active), 32'd0);
    endtask

    // Output side of the scoreboard: every peak_vld pops one expectation.
    always @(negedge clk) begin
        if (peak_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_peak_vld", 32'(peak_vld), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("peak", 32'(peak), 32'(mon_e.pk));
                check("over", 32'(over), 32'(mon_e.ov));
                check("hold_active", 32'(hold_active), 32'(mon_e.hd));
                if (STICKY && mon_e.ov) idle_over_exp = 1'b1;
            end
        end else begin
            check("over_between", 32'(over), 32'(idle_over_exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; smpl_vld = 1'b0; smpl = 16'h4000;

        // 1. reset with toggling valid
        for (int i = 0; i < 2; i++) begin
            smpl_vld = (i == 1);
            tick();
            check_zero("rst");
            check("rst_peak_vld", 32'(peak_vld), 32'd0);
        end
        rst = 1'b0; smpl_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("post_rst");
        end

        // 2. first sample from IDLE
        send(16'hC000, 15'h4000, 1'b0, 1'b1);
        drain("s2");
        tick(); tick();
        check("s2_peak_held", 32'(peak), 32'h4000);

        // refresh in HOLD, then hold for 4 samples, then decay
        send(16'h0100, 15'h4000, 1'b0, 1'b1);
        send(16'h0100, 15'h4000, 1'b0, 1'b1);
        send(16'h4000, 15'h4000, 1'b0, 1'b1);
        // 3. five smaller samples
        send(16'h0100, 15'h4000, 1'b0, 1'b1);
        send(16'h0100, 15'h4000, 1'b0, 1'b1);
        send(16'h0100, 15'h4000, 1'b0, 1'b1);
        send(16'h0100, 15'h4000, 1'b0, 1'b0);
        send(16'h0100, 15'h3000, 1'b0, 1'b0);
        // decay clamped at magnitude, then equal magnitude returns to HOLD
        send(16'h2F00, 15'h2F00, 1'b0, 1'b0);
        send(16'h2F00, 15'h2F00, 1'b0, 1'b1);
        drain("s3");

        // 4. full-scale negative clips
        send(16'h8000, 15'h7FFF, 1'b1, 1'b1);
        drain("s4a");
        tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle_over_exp = 1'b0;
        check_zero("s4a_clr");

        send(16'h7FFF, 15'h7FFF, 1'b1, 1'b1);
        drain("s4b");
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle_over_exp = 1'b0;
        check_zero("s4b_clr");

        // 5. small peak decays by the minimum step to zero and idles
        send(16'hFFFD, 15'h0003, 1'b0, 1'b1);
        send(16'h0000, 15'h0003, 1'b0, 1'b1);
        send(16'h0000, 15'h0003, 1'b0, 1'b1);
        send(16'h0000, 15'h0003, 1'b0, 1'b1);
        send(16'h0000, 15'h0003, 1'b0, 1'b0);
        send(16'h0000, 15'h0002, 1'b0, 1'b0);
        send(16'h0000, 15'h0001, 1'b0, 1'b0);
        send(16'h0000, 15'h0000, 1'b0, 1'b0);
        send(16'h0000, 15'h0000, 1'b0, 1'b0);
        drain("s5");
        check("s5_hold_idle", 32'(hold_active), 32'd0);

        // 6. clr with an in-flight sample and a coincident new sample
        send(16'h2000, 15'h2000, 1'b0, 1'b1);
        drain("s6a");
        smpl_vld = 1'b1; smpl = 16'h1000;
        tick();
        clr = 1'b1; smpl = 16'h7000;
        tick();
        clr = 1'b0; smpl_vld = 1'b0;
        idle_over_exp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_zero("s6_clr");
        end
        send(16'h0100, 15'h0100, 1'b0, 1'b1);
        drain("s6b");

        // reset mid-HOLD
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_mid_hold");
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
